// File: rtl/ddr_wr_pkg.sv
// Shared types and AXI constants for the DDR line-write AXI master.
package ddr_wr_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_AW   = 3'd1,
      ST_W    = 3'd2,
      ST_B    = 3'd3,
      ST_DONE = 3'd4
   } wr_state_e;

   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // AXI size code for one data beat; the beat is 8*dq_width bits wide.
   function automatic logic [2:0] axsize_f(input int dq_width);
      return 3'($clog2(dq_width));
   endfunction

endpackage

// File: rtl/ddr_wr_axi_master.sv
// Turns write-buffer line requests into AXI4 INCR write bursts of at most
// MAX_BURST beats, pulling data words with a same-cycle req/data handshake.
module ddr_wr_axi_master
   import ddr_wr_pkg::*;
#(
   parameter int ADDR_WIDTH     = 27,
   parameter int DQ_WIDTH       = 16,
   parameter int LEN_WIDTH      = 16,
   parameter int AXI_ADDR_WIDTH = 28,
   parameter int MAX_BURST      = 128
) (
   input  logic                      ddr_clk,
   input  logic                      ddr_rstn,
   input  logic                      ddr_wreq,
   input  logic [ADDR_WIDTH-1:0]     ddr_waddr,
   input  logic [LEN_WIDTH-1:0]      ddr_wr_len,
   output logic                      ddr_wrdy,
   output logic                      ddr_wdone,
   input  logic [8*DQ_WIDTH-1:0]     ddr_wdata,
   output logic                      ddr_wdata_req,
   output logic [AXI_ADDR_WIDTH-1:0] awaddr,
   output logic [7:0]                awlen,
   output logic [2:0]                awsize,
   output logic [1:0]                awburst,
   output logic                      awvalid,
   input  logic                      awready,
   output logic [8*DQ_WIDTH-1:0]     wdata,
   output logic [DQ_WIDTH-1:0]       wstrb,
   output logic                      wlast,
   output logic                      wvalid,
   input  logic                      wready,
   input  logic [1:0]                bresp,
   input  logic                      bvalid,
   output logic                      bready,
   output logic                      wr_err,
   output logic                      busy
);

   localparam int SUBW       = $clog2(MAX_BURST + 1);
   localparam int ADDR_SHIFT = $clog2(DQ_WIDTH / 8);
   localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_BURST);
   localparam logic [SUBW-1:0]      SUB_MAX = SUBW'(MAX_BURST);
   localparam logic [SUBW-1:0]      SUB_ONE = {{(SUBW-1){1'b0}}, 1'b1};
   localparam logic [2:0]           AW_SIZE = axsize_f(DQ_WIDTH);

   wr_state_e                 state_r;
   wr_state_e                 state_s;

   logic [ADDR_WIDTH-1:0]     word_addr_r;
   logic [LEN_WIDTH-1:0]      remaining_r;
   logic [SUBW-1:0]           sub_len_r;
   logic [SUBW-1:0]           beat_cnt_r;

   logic [AXI_ADDR_WIDTH-1:0] awaddr_r;
   logic [7:0]                awlen_r;
   logic                      awvalid_r;
   logic [8*DQ_WIDTH-1:0]     wdata_r;
   logic [DQ_WIDTH-1:0]       wstrb_r;
   logic                      wlast_r;
   logic                      wvalid_r;
   logic                      bready_r;
   logic                      wrdy_r;
   logic                      wdone_r;
   logic                      wr_err_r;
   logic                      busy_r;

   logic                      aw_hs_s;
   logic                      w_hs_s;
   logic                      b_hs_s;
   logic                      data_req_s;
   logic [LEN_WIDTH-1:0]      rem_after_s;
   logic [ADDR_WIDTH-1:0]     addr_after_s;
   logic [LEN_WIDTH-1:0]      load_rem_s;
   logic [ADDR_WIDTH-1:0]     load_addr_s;
   logic [SUBW-1:0]           load_sub_s;
   logic                      load_aw_s;

   // Handshakes, the word-pull request and the next-burst address/length.
   always_comb begin
      aw_hs_s      = awvalid_r & awready;
      w_hs_s       = wvalid_r & wready;
      b_hs_s       = bready_r & bvalid;
      data_req_s   = (state_r == ST_W) && (beat_cnt_r < sub_len_r) && (!wvalid_r || wready);
      rem_after_s  = remaining_r - LEN_WIDTH'(sub_len_r);
      // One data word spans eight DQ words.
      addr_after_s = word_addr_r + (ADDR_WIDTH'(sub_len_r) << 3'd3);
      if (state_r == ST_IDLE) begin
         load_rem_s  = ddr_wr_len;
         load_addr_s = ddr_waddr;
      end else begin
         load_rem_s  = rem_after_s;
         load_addr_s = addr_after_s;
      end
      if (load_rem_s > MAX_LEN) begin
         load_sub_s = SUB_MAX;
      end else begin
         load_sub_s = load_rem_s[SUBW-1:0];
      end
      load_aw_s = (state_s == ST_AW) && (state_r != ST_AW);
   end

   // Next-state decode for the request/burst sequencer.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (ddr_wreq) begin
               if (ddr_wr_len == {LEN_WIDTH{1'b0}}) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_AW;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_AW: begin
            if (aw_hs_s) begin
               state_s = ST_W;
            end else begin
               state_s = ST_AW;
            end
         end
         ST_W: begin
            if (w_hs_s && wlast_r) begin
               state_s = ST_B;
            end else begin
               state_s = ST_W;
            end
         end
         ST_B: begin
            if (b_hs_s) begin
               if (rem_after_s != {LEN_WIDTH{1'b0}}) begin
                  state_s = ST_AW;
               end else begin
                  state_s = ST_DONE;
               end
            end else begin
               state_s = ST_B;
            end
         end
         ST_DONE: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // Sequencer state register.
   always_ff @(posedge ddr_clk) begin
      if (!ddr_rstn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Request bookkeeping, AW/W channel registers and status pulses.
   always_ff @(posedge ddr_clk) begin
      if (!ddr_rstn) begin
         word_addr_r <= {ADDR_WIDTH{1'b0}};
         remaining_r <= {LEN_WIDTH{1'b0}};
         sub_len_r   <= {SUBW{1'b0}};
         beat_cnt_r  <= {SUBW{1'b0}};
         awaddr_r    <= {AXI_ADDR_WIDTH{1'b0}};
         awlen_r     <= 8'd0;
         awvalid_r   <= 1'b0;
         wdata_r     <= {(8*DQ_WIDTH){1'b0}};
         wstrb_r     <= {DQ_WIDTH{1'b0}};
         wlast_r     <= 1'b0;
         wvalid_r    <= 1'b0;
         bready_r    <= 1'b0;
         wrdy_r      <= 1'b0;
         wdone_r     <= 1'b0;
         wr_err_r    <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         if ((state_r == ST_IDLE) && ddr_wreq) begin
            word_addr_r <= ddr_waddr;
            remaining_r <= ddr_wr_len;
         end else if (b_hs_s) begin
            word_addr_r <= addr_after_s;
            remaining_r <= rem_after_s;
         end
         if (b_hs_s && (bresp != RESP_OKAY)) begin
            wr_err_r <= 1'b1;
         end
         if (load_aw_s) begin
            awvalid_r <= 1'b1;
            awaddr_r  <= AXI_ADDR_WIDTH'(load_addr_s) << ADDR_SHIFT;
            awlen_r   <= 8'(load_sub_s - SUB_ONE);
            sub_len_r <= load_sub_s;
         end else if (aw_hs_s) begin
            awvalid_r <= 1'b0;
         end
         if (aw_hs_s) begin
            beat_cnt_r <= {SUBW{1'b0}};
         end else if (data_req_s) begin
            beat_cnt_r <= beat_cnt_r + SUB_ONE;
         end
         // The W register refills in the cycle it drains, so a ready
         // slave sees one beat per cycle.
         if (data_req_s) begin
            wdata_r  <= ddr_wdata;
            wvalid_r <= 1'b1;
            wstrb_r  <= {DQ_WIDTH{1'b1}};
            wlast_r  <= (beat_cnt_r == (sub_len_r - SUB_ONE));
         end else if (w_hs_s) begin
            wvalid_r <= 1'b0;
            wlast_r  <= 1'b0;
         end
         wrdy_r   <= (state_r == ST_IDLE) && (state_s == ST_AW);
         wdone_r  <= (state_s == ST_DONE);
         bready_r <= (state_s == ST_B);
         busy_r   <= (state_s != ST_IDLE);
      end
   end

   assign ddr_wrdy      = wrdy_r;
   assign ddr_wdone     = wdone_r;
   assign ddr_wdata_req = data_req_s;
   assign awaddr        = awaddr_r;
   assign awlen         = awlen_r;
   assign awsize        = AW_SIZE;
   assign awburst       = BURST_INCR;
   assign awvalid       = awvalid_r;
   assign wdata         = wdata_r;
   assign wstrb         = wstrb_r;
   assign wlast         = wlast_r;
   assign wvalid        = wvalid_r;
   assign bready        = bready_r;
   assign wr_err        = wr_err_r;
   assign busy          = busy_r;

endmodule
